// File: rtl/tlc_multiway_if.sv
// Lamp/request bundle for the multi-way traffic light controller.
// master drives the requests and watches the lamps; slave is the controller.
interface tlc_multiway_if #(
  parameter int NUM_WAYS = 4
) ();
  logic                        on;
  logic                        flash_mode;
  logic [NUM_WAYS-1:0]         ped_req;
  logic [NUM_WAYS-1:0]         r;
  logic [NUM_WAYS-1:0]         y;
  logic [NUM_WAYS-1:0]         g;
  logic [NUM_WAYS-1:0]         walk;
  logic [$clog2(NUM_WAYS)-1:0] active_way;

  modport master (output on, flash_mode, ped_req,
                  input  r, y, g, walk, active_way);
  modport slave  (input  on, flash_mode, ped_req,
                  output r, y, g, walk, active_way);
endinterface

// File: rtl/tlc_multiway.sv
// Round-robin multi-way traffic light controller with latched pedestrian
// requests (extended green + walk) and a flashing-yellow night mode.
module tlc_multiway #(
  parameter int NUM_WAYS = 4,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int PED_EXT  = 4,
  parameter int FLASH_T  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  tlc_multiway_if.slave  bus
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int WW   = $clog2(NUM_WAYS);
  localparam int MAXD = imax(imax(GREEN_T + PED_EXT, YELLOW_T), imax(ALLRED_T, FLASH_T));
  localparam int CW   = $clog2(MAXD + 1);

  localparam logic [CW-1:0] LD_GREEN  = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] LD_GPED   = CW'(GREEN_T + PED_EXT - 1);
  localparam logic [CW-1:0] LD_YELLOW = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] LD_ALLRED = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] LD_FLASH  = CW'(FLASH_T - 1);
  localparam logic [WW-1:0] LAST_WAY  = WW'(NUM_WAYS - 1);

  typedef enum logic [2:0] {S_IDLE, S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_t;

  state_t              state, nxt_state;
  logic [WW-1:0]       way, nxt_way, gway;
  logic [CW-1:0]       cnt, nxt_cnt;
  logic                ph, nxt_ph;
  logic                grant, nxt_grant, go_green;
  logic [NUM_WAYS-1:0] pending, nxt_pending;
  logic [NUM_WAYS-1:0] o_r, o_y, o_g, o_walk;

  always_comb begin
    nxt_state   = state;
    nxt_way     = way;
    nxt_cnt     = cnt;
    nxt_ph      = ph;
    nxt_grant   = grant;
    nxt_pending = pending | bus.ped_req;
    go_green    = 1'b0;
    gway        = way;

    case (state)
      S_IDLE: begin
        if (bus.flash_mode) begin
          nxt_state = S_FLASH;
          nxt_cnt   = LD_FLASH;
          nxt_ph    = 1'b1;
        end else if (bus.on) begin
          go_green = 1'b1;
          gway     = '0;
        end
      end
      S_GREEN: begin
        if (!bus.on || bus.flash_mode || cnt == '0) begin
          nxt_state = S_YELLOW;
          nxt_cnt   = LD_YELLOW;
          nxt_grant = 1'b0;
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      S_YELLOW: begin
        if (cnt == '0) begin
          nxt_state = S_ALLRED;
          nxt_cnt   = LD_ALLRED;
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      S_ALLRED: begin
        if (cnt != '0) begin
          nxt_cnt = cnt - 1'b1;
        end else if (bus.flash_mode) begin
          nxt_state = S_FLASH;
          nxt_cnt   = LD_FLASH;
          nxt_ph    = 1'b1;
        end else if (!bus.on) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end else begin
          go_green = 1'b1;
          gway     = (way == LAST_WAY) ? '0 : way + 1'b1;
        end
      end
      S_FLASH: begin
        // Leaving night mode parks on the last way so the next green is way 0.
        if (!bus.flash_mode) begin
          nxt_state = S_ALLRED;
          nxt_cnt   = LD_ALLRED;
          nxt_way   = LAST_WAY;
          nxt_ph    = 1'b0;
        end else if (cnt == '0) begin
          nxt_cnt = LD_FLASH;
          nxt_ph  = ~ph;
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    if (go_green) begin
      nxt_state         = S_GREEN;
      nxt_way           = gway;
      nxt_grant         = pending[gway] | bus.ped_req[gway];
      nxt_cnt           = nxt_grant ? LD_GPED : LD_GREEN;
      nxt_pending[gway] = 1'b0;
    end

    // Lamps are decoded from the next state so the registered outputs line up with it.
    o_r    = '1;
    o_y    = '0;
    o_g    = '0;
    o_walk = '0;
    case (nxt_state)
      S_GREEN: begin
        o_g[nxt_way]    = 1'b1;
        o_r[nxt_way]    = 1'b0;
        o_walk[nxt_way] = nxt_grant;
      end
      S_YELLOW: begin
        o_y[nxt_way] = 1'b1;
        o_r[nxt_way] = 1'b0;
      end
      S_FLASH: begin
        o_r = '0;
        o_y = {NUM_WAYS{nxt_ph}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      way            <= '0;
      cnt            <= '0;
      ph             <= 1'b0;
      grant          <= 1'b0;
      pending        <= '0;
      bus.r          <= '1;
      bus.y          <= '0;
      bus.g          <= '0;
      bus.walk       <= '0;
      bus.active_way <= '0;
    end else begin
      state          <= nxt_state;
      way            <= nxt_way;
      cnt            <= nxt_cnt;
      ph             <= nxt_ph;
      grant          <= nxt_grant;
      pending        <= nxt_pending;
      bus.r          <= o_r;
      bus.y          <= o_y;
      bus.g          <= o_g;
      bus.walk       <= o_walk;
      bus.active_way <= nxt_way;
    end
  end

  a_single_way: assert property (@(posedge clk) disable iff (!rst_n)
    (state != S_FLASH) |-> $onehot0(bus.g | bus.y));
  a_green_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    (|bus.g) |-> ((bus.r | bus.g) == '1));

endmodule

// File: tb/tb_tlc_multiway.sv
// Randomised and directed bench for tlc_multiway against a phase/remaining-time
// model of the controller, plus literal timing expectations.
module tb_tlc_multiway;
  localparam int N  = 4;
  localparam int G  = 8;
  localparam int Y  = 3;
  localparam int AR = 2;
  localparam int PE = 4;
  localparam int F  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tlc_multiway_if #(.NUM_WAYS(N)) bus ();

  tlc_multiway #(
    .NUM_WAYS(N), .GREEN_T(G), .YELLOW_T(Y), .ALLRED_T(AR), .PED_EXT(PE), .FLASH_T(F)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 green, 2 yellow, 3 all-red, 4 flash; m_left = cycles still to show.
  int             m_phase = 0;
  int             m_left  = 0;
  int             m_way   = 0;
  int             m_fleft = 0;
  bit             m_walk  = 1'b0;
  bit             m_fon   = 1'b0;
  logic [N-1:0]   m_pend  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_left <= 0; m_way <= 0; m_fleft <= 0;
      m_walk  <= 1'b0; m_fon <= 1'b0; m_pend <= '0;
    end else begin : step
      int ph, left, way, fleft, sw;
      bit walk, fon;
      logic [N-1:0] p;
      ph = m_phase; left = m_left; way = m_way; fleft = m_fleft;
      walk = m_walk; fon = m_fon; p = m_pend | bus.ped_req; sw = -1;
      case (m_phase)
        0: if (bus.flash_mode) begin ph = 4; fon = 1'b1; fleft = F; end
           else if (bus.on) sw = 0;
        1: if (!bus.on || bus.flash_mode || left == 1) begin ph = 2; left = Y; walk = 1'b0; end
           else left--;
        2: if (left == 1) begin ph = 3; left = AR; end else left--;
        3: if (left == 1) begin
             if (bus.flash_mode) begin ph = 4; fon = 1'b1; fleft = F; end
             else if (!bus.on) ph = 0;
             else sw = (way + 1) % N;
           end else left--;
        4: if (!bus.flash_mode) begin ph = 3; left = AR; way = N - 1; end
           else if (fleft == 1) begin fon = !fon; fleft = F; end
           else fleft--;
        default: ph = 0;
      endcase
      if (sw >= 0) begin
        ph = 1; way = sw; walk = p[sw]; p[sw] = 1'b0;
        left = G + (walk ? PE : 0);
      end
      m_phase <= ph; m_left <= left; m_way <= way; m_fleft <= fleft;
      m_walk <= walk; m_fon <= fon; m_pend <= p;
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] er, ey, eg, ew;
    if (rst_n === 1'b1) begin
      er = '1; ey = '0; eg = '0; ew = '0;
      case (m_phase)
        1: begin eg[m_way] = 1'b1; er[m_way] = 1'b0; ew[m_way] = m_walk; end
        2: begin ey[m_way] = 1'b1; er[m_way] = 1'b0; end
        4: begin er = '0; ey = {N{m_fon}}; end
        default: ;
      endcase
      chk("model_r", bus.r, er);
      chk("model_y", bus.y, ey);
      chk("model_g", bus.g, eg);
      chk("model_walk", bus.walk, ew);
      chk("model_active_way", bus.active_way, m_way);
    end
  end

  task automatic measure(input int way, input int pulse_at, input logic [N-1:0] mask,
                         input int drop_at, input int flash_at,
                         output int len, output bit wall, output bit wany);
    int waited;
    waited = 0; len = 0; wall = 1'b1; wany = 1'b0;
    while (!bus.g[way] && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.g[way]) begin
      checks++; errors++;
      $display("FAIL wait_green_way%0d: got no green within 300 cycles, required green", way);
      wall = 1'b0;
      return;
    end
    while (bus.g[way] && len < 100) begin
      len++;
      if (bus.walk[way]) wany = 1'b1; else wall = 1'b0;
      bus.ped_req = (len == pulse_at) ? mask : '0;
      if (len == drop_at)  bus.on = 1'b0;
      if (len == flash_at) bus.flash_mode = 1'b1;
      @(negedge clk);
    end
    bus.ped_req = '0;
  endtask

  logic [N-1:0] tg [0:60];
  logic [N-1:0] ty [0:60];
  logic [N-1:0] walk_or;
  int  len, k;
  bit  wall, wany;

  initial begin
    rst_n = 1'b0;
    bus.on = 1'b0; bus.flash_mode = 1'b0; bus.ped_req = '0;
    repeat (3) @(negedge clk);
    chk("reset_r", bus.r, 4'b1111);
    chk("reset_y", bus.y, 4'b0000);
    chk("reset_g", bus.g, 4'b0000);
    chk("reset_walk", bus.walk, 4'b0000);
    chk("reset_active_way", bus.active_way, 0);

    // Rotation from reset
    rst_n = 1'b1; bus.on = 1'b1;
    walk_or = '0;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      tg[t] = bus.g; ty[t] = bus.y; walk_or |= bus.walk;
    end
    chk("rot_g_first", tg[1], 4'b0001);
    chk("rot_g_last", tg[8], 4'b0001);
    chk("rot_y_first", ty[9], 4'b0001);
    chk("rot_y_last", ty[11], 4'b0001);
    chk("rot_allred_a", tg[12] | ty[12], 4'b0000);
    chk("rot_allred_b", tg[13] | ty[13], 4'b0000);
    chk("rot_way1", tg[14], 4'b0010);
    chk("rot_way2", tg[27], 4'b0100);
    chk("rot_way3", tg[40], 4'b1000);
    chk("rot_wrap_allred", tg[52] | ty[52], 4'b0000);
    chk("rot_wrap_way0", tg[53], 4'b0001);
    chk("rot_no_walk", walk_or, 4'b0000);

    // Pedestrian request for way 2 while way 0 is green
    bus.ped_req = 4'b0100;
    @(negedge clk);
    bus.ped_req = '0;
    measure(2, 0, '0, 0, 0, len, wall, wany);
    chk("ped2_len", len, 12);
    chk("ped2_walk_all", wall, 1);
    measure(2, 0, '0, 0, 0, len, wall, wany);
    chk("ped2_next_len", len, 8);
    chk("ped2_next_walk", wany, 0);

    // Request for way 1 while way 1 is green waits for its next green
    measure(1, 1, 4'b0010, 0, 0, len, wall, wany);
    chk("ped1_cur_len", len, 8);
    chk("ped1_cur_walk", wany, 0);
    measure(1, 0, '0, 0, 0, len, wall, wany);
    chk("ped1_next_len", len, 12);
    chk("ped1_next_walk", wall, 1);

    // Switch off on the third green cycle of way 1
    measure(1, 0, '0, 3, 0, len, wall, wany);
    chk("off_green_len", len, 3);
    chk("off_y1", bus.y, 4'b0010);
    repeat (2) @(negedge clk);
    chk("off_y3", bus.y, 4'b0010);
    @(negedge clk);
    chk("off_allred1", bus.r, 4'b1111);
    @(negedge clk);
    chk("off_allred2", bus.r, 4'b1111);
    repeat (3) @(negedge clk);
    chk("idle_r", bus.r, 4'b1111);
    chk("idle_gy", bus.g | bus.y, 4'b0000);

    // Night mode requested during way 2 green
    bus.on = 1'b1;
    measure(2, 0, '0, 0, 1, len, wall, wany);
    chk("flash_green_len", len, 1);
    repeat (2) @(negedge clk);
    chk("flash_pre_y3", bus.y, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    chk("flash_pre_allred", bus.r, 4'b1111);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("flash_y", bus.y, (((i / F) % 2) == 0) ? 32'hf : 32'h0);
      chk("flash_r", bus.r, 4'b0000);
    end
    bus.flash_mode = 1'b0;
    @(negedge clk);
    chk("unflash_allred1", bus.r, 4'b1111);
    chk("unflash_way", bus.active_way, N - 1);
    @(negedge clk);
    chk("unflash_allred2", bus.r, 4'b1111);
    @(negedge clk);
    chk("unflash_way0", bus.g, 4'b0001);

    // Asynchronous reset in the middle of a yellow
    k = 0;
    while (bus.y == '0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rst_found_yellow", bus.y, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_r", bus.r, 4'b1111);
    chk("async_rst_y", bus.y, 4'b0000);
    chk("async_rst_g", bus.g, 4'b0000);
    chk("async_rst_way", bus.active_way, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_way0", bus.g, 4'b0001);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.ped_req = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 79) == 0)  bus.on = ~bus.on;
      if ($urandom_range(0, 199) == 0) bus.flash_mode = ~bus.flash_mode;
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
